fwd_operand_stage: RTL and testbench

Parametrised ID/EX operand stage with built-in forwarding for the MIPS pipeline. Resolves NSRC source operands per instruction from the register file, the immediate, the instruction currently leaving EX, or a DEPTH-entry writeback history. It detects load-use hazards and requests a stall, and registers the resolved operands into EX. It replaces the per-operand forwarding mux and the external forwarding unit with one sequential block.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/fwd_resolve.sv | 53 +++++
 rtl/fwd_operand_stage.sv | 113 +++++++++++
 tb/tb_fwd_operand_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS operand/forwarding logic.
package mips_pkg;

  // Forward-select codes reported per operand
  localparam int unsigned SEL_RF        = 0;
  localparam int unsigned SEL_IMM       = 1;
  localparam int unsigned SEL_EX        = 2;
  localparam int unsigned SEL_HIST_BASE = 3;

  // History storage widths: upper bound for the stage data/register widths
  localparam int unsigned HIST_DATA_W = 64;
  localparam int unsigned HIST_RD_W   = 8;

  // One writeback-history entry
  typedef struct packed {
    logic                   valid;
    logic                   ready;
    logic [HIST_RD_W-1:0]   rd;
    logic [HIST_DATA_W-1:0] data;
  } hist_t;

endpackage

// File: rtl/fwd_resolve.sv
// Per-operand source resolution: immediate, r0, EX result, or youngest history match.
module fwd_resolve
  import mips_pkg::*;
#(
  parameter int unsigned NBITS   = 32,
  parameter int unsigned RBITS   = 5,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned SELBITS = 3
) (
  input  logic [RBITS-1:0]   rs,
  input  logic [NBITS-1:0]   rf_data,
  input  logic               use_imm,
  input  logic [NBITS-1:0]   imm,
  input  logic               ex_wr_en,
  input  logic [RBITS-1:0]   ex_rd,
  input  logic [NBITS-1:0]   ex_result,
  input  logic               ex_is_load,
  input  hist_t [DEPTH-1:0]  hist,
  output logic [NBITS-1:0]   data_c,
  output logic [SELBITS-1:0] sel_c,
  output logic               stall_c
);

  // History data/rd are stored wider than this stage may need
  logic unused_hist;
  assign unused_hist = ^hist;

  // Priority search; history scanned oldest-first so the youngest match lands last
  always_comb begin
    data_c  = rf_data;
    sel_c   = SELBITS'(SEL_RF);
    stall_c = 1'b0;
    if (use_imm) begin
      data_c = imm;
      sel_c  = SELBITS'(SEL_IMM);
    end else if (rs != '0) begin
      if (ex_wr_en && (ex_rd == rs)) begin
        data_c  = ex_result;
        sel_c   = SELBITS'(SEL_EX);
        stall_c = ex_is_load;
      end else begin
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
          if (hist[k].valid && (hist[k].rd == HIST_RD_W'(rs))) begin
            data_c  = NBITS'(hist[k].data);
            sel_c   = SELBITS'(SEL_HIST_BASE + 32'(k));
            stall_c = !hist[k].ready;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fwd_operand_stage.sv
// ID/EX operand stage with integrated forwarding, load-use stall and writeback history.
module fwd_operand_stage
  import mips_pkg::*;
#(
  parameter  int unsigned NBITS    = 32,
  parameter  int unsigned RBITS    = 5,
  parameter  int unsigned NSRC     = 2,
  parameter  int unsigned DEPTH    = 2,
  parameter  int unsigned LD_STAGE = 0,
  localparam int unsigned SELBITS  = $clog2(DEPTH + 3)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_id_valid,
  input  logic [NSRC*RBITS-1:0]   i_rs,
  input  logic [NSRC*NBITS-1:0]   i_rf_data,
  input  logic [NSRC-1:0]         i_use_imm,
  input  logic [NBITS-1:0]        i_imm,
  input  logic                    i_ex_wr_en,
  input  logic [RBITS-1:0]        i_ex_rd,
  input  logic [NBITS-1:0]        i_ex_result,
  input  logic                    i_ex_is_load,
  input  logic                    i_ld_valid,
  input  logic [NBITS-1:0]        i_ld_data,
  input  logic                    i_flush,
  output logic                    o_stall,
  output logic                    o_ex_valid,
  output logic [NSRC*NBITS-1:0]   o_ex_operands,
  output logic [NSRC*SELBITS-1:0] o_fwd_sel
);

  hist_t [DEPTH-1:0] hist_q;
  hist_t [DEPTH-1:0] hist_eff;
  hist_t             ex_entry;

  logic [NSRC-1:0]              op_stall;
  logic [NSRC-1:0][NBITS-1:0]   op_data;
  logic [NSRC-1:0][SELBITS-1:0] op_sel;
  logic                         ex_load;

  // History as seen this cycle: a pending load at LD_STAGE is completed by i_ld_data
  always_comb begin
    hist_eff = hist_q;
    if (i_ld_valid && hist_q[LD_STAGE].valid && !hist_q[LD_STAGE].ready) begin
      hist_eff[LD_STAGE].ready = 1'b1;
      hist_eff[LD_STAGE].data  = HIST_DATA_W'(i_ld_data);
    end
  end

  // Entry captured from the instruction leaving EX; writes to r0 are never recorded
  always_comb begin
    ex_entry       = '0;
    ex_entry.valid = i_ex_wr_en && (i_ex_rd != '0);
    ex_entry.ready = !i_ex_is_load;
    ex_entry.rd    = HIST_RD_W'(i_ex_rd);
    ex_entry.data  = HIST_DATA_W'(i_ex_result);
  end

  // History shifts every cycle, stalls included, since EX receives a bubble then
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hist_q <= '0;
    end else begin
      hist_q[0] <= ex_entry;
      for (int k = 1; k < int'(DEPTH); k++) begin
        hist_q[k] <= hist_eff[k-1];
      end
    end
  end

  // One resolver per source operand
  for (genvar j = 0; j < int'(NSRC); j++) begin : g_src
    fwd_resolve #(
      .NBITS   (NBITS),
      .RBITS   (RBITS),
      .DEPTH   (DEPTH),
      .SELBITS (SELBITS)
    ) u_resolve (
      .rs         (i_rs[j*RBITS +: RBITS]),
      .rf_data    (i_rf_data[j*NBITS +: NBITS]),
      .use_imm    (i_use_imm[j]),
      .imm        (i_imm),
      .ex_wr_en   (i_ex_wr_en),
      .ex_rd      (i_ex_rd),
      .ex_result  (i_ex_result),
      .ex_is_load (i_ex_is_load),
      .hist       (hist_eff),
      .data_c     (op_data[j]),
      .sel_c      (op_sel[j]),
      .stall_c    (op_stall[j])
    );
  end

  // Stall request is combinational and suppressed while reset is held
  assign o_stall = i_reset_n & i_id_valid & (|op_stall);
  assign ex_load = i_id_valid & ~o_stall & ~i_flush;

  // EX register: operands/selects only update when a real instruction enters EX
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_ex_valid    <= 1'b0;
      o_ex_operands <= '0;
      o_fwd_sel     <= '0;
    end else begin
      o_ex_valid <= ex_load;
      if (ex_load) begin
        o_ex_operands <= op_data;
        o_fwd_sel     <= op_sel;
      end
    end
  end

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Scoreboard bench for fwd_operand_stage: directed vectors, decoupled monitor.
module tb_fwd_operand_stage;

  localparam int unsigned NBITS   = 32;
  localparam int unsigned RBITS   = 5;
  localparam int unsigned NSRC    = 2;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned SELBITS = 3;

  logic                    clk;
  logic                    rst_n;
  logic                    id_valid;
  logic [NSRC*RBITS-1:0]   rs;
  logic [NSRC*NBITS-1:0]   rf_data;
  logic [NSRC-1:0]         use_imm;
  logic [NBITS-1:0]        imm;
  logic                    ex_wr_en;
  logic [RBITS-1:0]        ex_rd;
  logic [NBITS-1:0]        ex_result;
  logic                    ex_is_load;
  logic                    ld_valid;
  logic [NBITS-1:0]        ld_data;
  logic                    flush;
  logic                    stall;
  logic                    ex_valid;
  logic [NSRC*NBITS-1:0]   ex_operands;
  logic [NSRC*SELBITS-1:0] fwd_sel;

  fwd_operand_stage #(
    .NBITS    (NBITS),
    .RBITS    (RBITS),
    .NSRC     (NSRC),
    .DEPTH    (DEPTH),
    .LD_STAGE (0)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_id_valid    (id_valid),
    .i_rs          (rs),
    .i_rf_data     (rf_data),
    .i_use_imm     (use_imm),
    .i_imm         (imm),
    .i_ex_wr_en    (ex_wr_en),
    .i_ex_rd       (ex_rd),
    .i_ex_result   (ex_result),
    .i_ex_is_load  (ex_is_load),
    .i_ld_valid    (ld_valid),
    .i_ld_data     (ld_data),
    .i_flush       (flush),
    .o_stall       (stall),
    .o_ex_valid    (ex_valid),
    .o_ex_operands (ex_operands),
    .o_fwd_sel     (fwd_sel)
  );

  typedef struct {
    logic [NSRC*NBITS-1:0]   ops;
    logic [NSRC*SELBITS-1:0] sels;
    string                   name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every instruction entering EX is checked against the scoreboard
  always @(negedge clk) begin
    if (rst_n && ex_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_ex_valid: got ops 0x%0h with empty scoreboard", ex_operands);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_ops"}, 64'(ex_operands), 64'(mon_e.ops));
        chk({mon_e.name, "_sel"}, 64'(fwd_sel), 64'(mon_e.sels));
      end
    end
  end

  task automatic setv(input logic wr, input logic [4:0] erd, input logic [31:0] eres,
                      input logic ld, input logic [4:0] rs0, input logic [31:0] rf0,
                      input logic [4:0] rs1, input logic [31:0] rf1);
    id_valid   = 1'b1;
    ex_wr_en   = wr;
    ex_rd      = erd;
    ex_result  = eres;
    ex_is_load = ld;
    rs         = {rs1, rs0};
    rf_data    = {rf1, rf0};
    use_imm    = '0;
    imm        = '0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    flush      = 1'b0;
  endtask

  // Check the stall, queue the expected EX contents, then advance one clock
  task automatic cyc(input string name, input logic exp_stall, input logic exp_valid,
                     input logic [31:0] e0, input logic [2:0] s0,
                     input logic [31:0] e1, input logic [2:0] s1);
    exp_t e;
    #1;
    chk({name, "_stall"}, 64'(stall), 64'(exp_stall));
    if (exp_valid) begin
      e.ops  = {e1, e0};
      e.sels = {s1, s0};
      e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!exp_valid) chk({name, "_bubble"}, 64'(ex_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    setv(1'b1, 5'd4, 32'h0, 1'b1, 5'd4, 32'h1004, 5'd31, 32'h31);
    #2;
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_valid", 64'(ex_valid), 64'd0);
    chk("reset_ops", 64'(ex_operands), 64'd0);
    chk("reset_sel", 64'(fwd_sel), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    setv(1'b1, 5'd3, 32'h10, 1'b0, 5'd3, 32'h1003, 5'd31, 32'h31);
    cyc("alu_b2b", 1'b0, 1'b1, 32'h10, 3'd2, 32'h31, 3'd0);
    setv(1'b1, 5'd5, 32'hAA, 1'b0, 5'd3, 32'h1003, 5'd31, 32'h31);
    cyc("hist0_r3", 1'b0, 1'b1, 32'h10, 3'd3, 32'h31, 3'd0);
    setv(1'b0, 5'd5, 32'hBB, 1'b0, 5'd5, 32'h1005, 5'd3, 32'h1003);
    cyc("ex_nowrite", 1'b0, 1'b1, 32'hAA, 3'd3, 32'h10, 3'd4);
    setv(1'b1, 5'd5, 32'hBB, 1'b0, 5'd5, 32'h1005, 5'd5, 32'h1005);
    cyc("youngest_ex", 1'b0, 1'b1, 32'hBB, 3'd2, 32'hBB, 3'd2);
    setv(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 32'h1003, 5'd5, 32'h1005);
    cyc("aged_out", 1'b0, 1'b1, 32'h1003, 3'd0, 32'hBB, 3'd3);

    setv(1'b1, 5'd4, 32'hDEAD, 1'b1, 5'd4, 32'h1004, 5'd31, 32'h31);
    cyc("load_use", 1'b1, 1'b0, 32'h0, 3'd0, 32'h0, 3'd0);
    setv(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 32'h1004, 5'd31, 32'h31);
    ld_valid = 1'b1;
    ld_data  = 32'h1234;
    cyc("load_fill", 1'b0, 1'b1, 32'h1234, 3'd3, 32'h31, 3'd0);
    setv(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 32'h1004, 5'd31, 32'h31);
    cyc("fill_hist1", 1'b0, 1'b1, 32'h1234, 3'd4, 32'h31, 3'd0);

    setv(1'b1, 5'd6, 32'h600, 1'b1, 5'd7, 32'h1007, 5'd31, 32'h31);
    cyc("lw_no_dep", 1'b0, 1'b1, 32'h1007, 3'd0, 32'h31, 3'd0);
    setv(1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 32'h1006, 5'd31, 32'h31);
    cyc("hist_notready", 1'b1, 1'b0, 32'h0, 3'd0, 32'h0, 3'd0);
    setv(1'b1, 5'd6, 32'h66, 1'b0, 5'd6, 32'h1006, 5'd31, 32'h31);
    cyc("ex_over_notready", 1'b0, 1'b1, 32'h66, 3'd2, 32'h31, 3'd0);

    setv(1'b1, 5'd8, 32'h88, 1'b0, 5'd31, 32'h31, 5'd31, 32'h31);
    cyc("r8_write", 1'b0, 1'b1, 32'h31, 3'd0, 32'h31, 3'd0);
    setv(1'b1, 5'd8, 32'h800, 1'b1, 5'd31, 32'h31, 5'd31, 32'h31);
    cyc("r8_load", 1'b0, 1'b1, 32'h31, 3'd0, 32'h31, 3'd0);
    setv(1'b0, 5'd0, 32'h0, 1'b0, 5'd8, 32'h1008, 5'd31, 32'h31);
    cyc("young_notready", 1'b1, 1'b0, 32'h0, 3'd0, 32'h0, 3'd0);
    setv(1'b0, 5'd0, 32'h0, 1'b0, 5'd8, 32'h1008, 5'd31, 32'h31);
    ld_valid = 1'b1;
    ld_data  = 32'h999;
    cyc("fill_wrong_stage", 1'b1, 1'b0, 32'h0, 3'd0, 32'h0, 3'd0);
    setv(1'b0, 5'd0, 32'h0, 1'b0, 5'd8, 32'h1008, 5'd31, 32'h31);
    cyc("dropped", 1'b0, 1'b1, 32'h1008, 3'd0, 32'h31, 3'd0);

    setv(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0, 5'd31, 32'h31);
    cyc("r0", 1'b0, 1'b1, 32'h0, 3'd0, 32'h31, 3'd0);
    setv(1'b1, 5'd9, 32'h900, 1'b1, 5'd9, 32'h1009, 5'd31, 32'h31);
    use_imm = 2'b01;
    imm     = 32'h7;
    cyc("imm", 1'b0, 1'b1, 32'h7, 3'd1, 32'h31, 3'd0);

    setv(1'b0, 5'd0, 32'h0, 1'b0, 5'd31, 32'h31, 5'd31, 32'h31);
    flush = 1'b1;
    cyc("flush", 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 3'd0);
    chk("flush_hold_ops", 64'(ex_operands), 64'h00000031_00000007);
    chk("flush_hold_sel", 64'(fwd_sel), 64'({3'd0, 3'd1}));
    setv(1'b1, 5'd10, 32'h0, 1'b1, 5'd10, 32'h100A, 5'd31, 32'h31);
    flush = 1'b1;
    cyc("flush_stall", 1'b1, 1'b0, 32'h0, 3'd0, 32'h0, 3'd0);
    setv(1'b1, 5'd4, 32'h0, 1'b1, 5'd4, 32'h1004, 5'd31, 32'h31);
    id_valid = 1'b0;
    cyc("id_invalid", 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 3'd0);

    setv(1'b1, 5'd4, 32'h0, 1'b1, 5'd4, 32'h1004, 5'd31, 32'h31);
    #1;
    chk("pre_reset_stall", 64'(stall), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_stall", 64'(stall), 64'd0);
    chk("midreset_valid", 64'(ex_valid), 64'd0);
    chk("midreset_ops", 64'(ex_operands), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    setv(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 32'h1004, 5'd31, 32'h31);
    cyc("after_reset", 1'b0, 1'b1, 32'h1004, 3'd0, 32'h31, 3'd0);

    id_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
